// File: rtl/spi_master_if.sv
// Byte-level handshake and SPI pin bundle between the LCD controller and spi_master.
// The master modport is the SPI engine's view; the slave modport is the controller's view.
interface spi_master_if;
  logic       spi_enable;
  logic [7:0] spi_data;
  logic       spi_busy;
  logic       spi_ready;
  logic       sclk;
  logic       mosi;

  modport master (
    input  spi_enable,
    input  spi_data,
    output spi_busy,
    output spi_ready,
    output sclk,
    output mosi
  );

  modport slave (
    output spi_enable,
    output spi_data,
    input  spi_busy,
    input  spi_ready,
    input  sclk,
    input  mosi
  );
endinterface

// File: rtl/spi_master.sv
// Mode-0 SPI byte transmitter, MSB first, SCLK half-period of CLK_DIV clk cycles.
// All outputs come straight from registers; power-up values match reset values.
module spi_master #(
  parameter int CLK_DIV = 2
) (
  input  logic         clk,
  input  logic         rst,
  spi_master_if.master bus
);

  localparam logic [7:0] HALF_M1 = 8'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t     r_state  = IDLE;
  logic [7:0] r_shreg  = 8'h00;
  logic [7:0] r_hcnt   = 8'h00;
  logic [2:0] r_bitcnt = 3'd0;
  logic       r_sclk   = 1'b0;
  logic       r_mosi   = 1'b0;
  logic       r_busy   = 1'b0;
  logic       r_ready  = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_shreg  <= 8'h00;
      r_hcnt   <= 8'h00;
      r_bitcnt <= 3'd0;
      r_sclk   <= 1'b0;
      r_mosi   <= 1'b0;
      r_busy   <= 1'b0;
      r_ready  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_sclk   <= 1'b0;
          r_mosi   <= 1'b0;
          r_busy   <= 1'b0;
          r_ready  <= 1'b0;
          r_hcnt   <= 8'h00;
          r_bitcnt <= 3'd0;
          if (bus.spi_enable) begin
            // MSB goes out in the first SHIFT cycle, ahead of the first rising edge
            r_shreg <= bus.spi_data;
            r_mosi  <= bus.spi_data[7];
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end
        end

        SHIFT: begin
          if (r_hcnt == HALF_M1) begin
            r_hcnt <= 8'h00;
            r_sclk <= ~r_sclk;
            if (r_sclk) begin
              // Falling edge: either finish on the 8th or present the next bit
              if (r_bitcnt == 3'd7) begin
                r_state  <= DONE;
                r_sclk   <= 1'b0;
                r_mosi   <= 1'b0;
                r_busy   <= 1'b0;
                r_ready  <= 1'b1;
                r_bitcnt <= 3'd0;
              end else begin
                r_shreg  <= {r_shreg[6:0], 1'b0};
                r_mosi   <= r_shreg[6];
                r_bitcnt <= r_bitcnt + 3'd1;
              end
            end
          end else begin
            r_hcnt <= r_hcnt + 8'd1;
          end
        end

        DONE: begin
          r_ready <= 1'b0;
          r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.sclk      = r_sclk;
  assign bus.mosi      = r_mosi;
  assign bus.spi_busy  = r_busy;
  assign bus.spi_ready = r_ready;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master at CLK_DIV = 1, 2 and 255, checked cycle by cycle against a
// timing model derived from the byte-transfer rules, plus a bit-capturing monitor.
module tb_spi_master;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  int divs [3] = '{1, 2, 255};

  spi_master_if bus0 ();
  spi_master_if bus1 ();
  spi_master_if bus2 ();

  spi_master #(.CLK_DIV(1))   u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  spi_master #(.CLK_DIV(2))   u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  spi_master #(.CLK_DIV(255)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: outputs {busy, ready, sclk, mosi} in cycle t after the acceptance edge
  function automatic logic [3:0] model(input int d, input logic [7:0] b, input int t);
    int h;
    if (t >= 1 && t <= 16 * d) begin
      h = (t - 1) / d;
      return {1'b1, 1'b0, ((h % 2) != 0), b[7 - h / 2]};
    end else if (t == 16 * d + 1) begin
      return 4'b0100;
    end
    return 4'b0000;
  endfunction

  function automatic logic [3:0] obs(input int sel);
    case (sel)
      0:       return {bus0.spi_busy, bus0.spi_ready, bus0.sclk, bus0.mosi};
      1:       return {bus1.spi_busy, bus1.spi_ready, bus1.sclk, bus1.mosi};
      default: return {bus2.spi_busy, bus2.spi_ready, bus2.sclk, bus2.mosi};
    endcase
  endfunction

  task automatic set_in(input int sel, input logic en, input logic [7:0] d);
    case (sel)
      0:       begin bus0.spi_enable = en; bus0.spi_data = d; end
      1:       begin bus1.spi_enable = en; bus1.spi_data = d; end
      default: begin bus2.spi_enable = en; bus2.spi_data = d; end
    endcase
  endtask

  task automatic chk(input string tag, input int t, input logic [3:0] o, input logic [3:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s t=%0d observed=%b expected=%b", tag, t, o, e);
    end
  endtask

  task automatic chk_int(input string tag, input int o, input int e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  // One-cycle enable pulse; the following posedge is the acceptance edge
  task automatic accept(input int sel, input logic [7:0] b);
    set_in(sel, 1'b1, b);
    @(posedge clk);
    #1 set_in(sel, 1'b0, b);
  endtask

  // Check cycles 1..tmax after acceptance; optionally change spi_data after cycle chg_at
  task automatic check_xfer(input string tag, input int sel, input logic [7:0] b,
                            input int tmax, input int chg_at, input logic [7:0] chg_val);
    for (int t = 1; t <= tmax; t++) begin
      @(negedge clk);
      chk(tag, t, obs(sel), model(divs[sel], b, t));
      if (t == chg_at) set_in(sel, 1'b0, chg_val);
    end
  endtask

  task automatic wait_bit(input string tag, input int sel, input int bitpos, input int limit);
    logic [3:0] o;
    logic       seen;
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      o = obs(sel);
      seen = o[bitpos];
    end
    checks++;
    assert (seen) else begin
      errors++;
      $error("FAIL %s observed=timeout expected=signal within %0d cycles", tag, limit);
    end
  endtask

  // Monitor on the CLK_DIV=2 instance: bytes captured on sclk rises, starts, ready pulses
  logic [7:0] m_byte = 8'h00;
  int         m_nbits = 0;
  int         m_readies = 0;
  logic       m_prev_sclk = 1'b0;
  logic       m_prev_busy = 1'b0;
  logic [7:0] m_bytes [$];
  int         m_starts [$];

  always @(negedge clk) begin
    if (!bus1.spi_busy) m_nbits = 0;
    if (bus1.sclk && !m_prev_sclk) begin
      m_byte = {m_byte[6:0], bus1.mosi};
      m_nbits++;
      if (m_nbits == 8) begin
        m_bytes.push_back(m_byte);
        m_nbits = 0;
      end
    end
    if (bus1.spi_busy && !m_prev_busy) m_starts.push_back(cyc);
    if (bus1.spi_ready) m_readies++;
    m_prev_sclk = bus1.sclk;
    m_prev_busy = bus1.spi_busy;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] b;
    logic [7:0] cv;
    int         ca;
    int         r0;

    for (int s = 0; s < 3; s++) set_in(s, 1'b0, 8'h00);

    #2;
    for (int s = 0; s < 3; s++) chk("powerup", 0, obs(s), 4'b0000);

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 3; s++) chk("reset", 0, obs(s), 4'b0000);
    rst = 1'b0;
    @(negedge clk);

    // Single A5 byte at default divider
    accept(1, 8'hA5);
    check_xfer("a5_d2", 1, 8'hA5, 34, 0, 8'h00);
    chk_int("a5_bytes_n", m_bytes.size(), 1);
    if (m_bytes.size() > 0) chk_int("a5_byte", int'(m_bytes[0]), 32'hA5);

    // Data changes mid-byte must not disturb the byte in flight
    accept(1, 8'h3A);
    check_xfer("3a_chg", 1, 8'h3A, 34, 5, 8'hFF);

    // Reset at cycle +10 of an 0x55 transfer, then 0x29 right after reset drops
    r0 = m_readies;
    accept(1, 8'h55);
    check_xfer("55_pre_rst", 1, 8'h55, 10, 0, 8'h00);
    rst = 1'b1;
    @(negedge clk);
    chk("55_rst", 11, obs(1), 4'b0000);
    rst = 1'b0;
    accept(1, 8'h29);
    check_xfer("29_after_rst", 1, 8'h29, 34, 0, 8'h00);
    chk_int("abort_readies", m_readies - r0, 1);

    // Reset concurrent with enable: byte not accepted
    rst = 1'b1;
    set_in(1, 1'b1, 8'hAA);
    @(posedge clk);
    #1 rst = 1'b0;
    set_in(1, 1'b0, 8'hAA);
    for (int t = 1; t <= 3; t++) begin
      @(negedge clk);
      chk("rst_and_en", t, obs(1), 4'b0000);
    end

    // Divider extremes
    accept(0, 8'h80);
    check_xfer("80_d1", 0, 8'h80, 18, 0, 8'h00);
    accept(0, 8'h01);
    check_xfer("01_d1", 0, 8'h01, 18, 0, 8'h00);
    accept(2, 8'h80);
    check_xfer("80_d255", 2, 8'h80, 4082, 0, 8'h00);
    accept(2, 8'h01);
    check_xfer("01_d255", 2, 8'h01, 4082, 0, 8'h00);

    // LCD-style handshake: enable held until busy, two bytes
    m_bytes.delete();
    r0 = m_readies;
    set_in(1, 1'b1, 8'h01);
    wait_bit("hs_busy0", 1, 3, 10);
    set_in(1, 1'b0, 8'h01);
    wait_bit("hs_ready0", 1, 2, 40);
    set_in(1, 1'b1, 8'h11);
    wait_bit("hs_busy1", 1, 3, 10);
    set_in(1, 1'b0, 8'h11);
    wait_bit("hs_ready1", 1, 2, 40);
    repeat (5) @(negedge clk);
    chk_int("hs_readies", m_readies - r0, 2);
    chk_int("hs_bytes_n", m_bytes.size(), 2);
    if (m_bytes.size() == 2) begin
      chk_int("hs_byte0", int'(m_bytes[0]), 32'h01);
      chk_int("hs_byte1", int'(m_bytes[1]), 32'h11);
    end

    // Held enable: acceptances exactly 2+16*CLK_DIV apart
    m_bytes.delete();
    m_starts.delete();
    set_in(1, 1'b1, 8'hEF);
    for (int i = 0; i < 120 && m_starts.size() < 3; i++) @(negedge clk);
    set_in(1, 1'b0, 8'hEF);
    chk_int("held_starts", m_starts.size(), 3);
    if (m_starts.size() >= 3) begin
      chk_int("held_gap0", m_starts[1] - m_starts[0], 34);
      chk_int("held_gap1", m_starts[2] - m_starts[1], 34);
    end
    repeat (40) @(negedge clk);
    for (int i = 0; i < m_bytes.size(); i++) chk_int("held_byte", int'(m_bytes[i]), 32'hEF);

    // Randomized bytes with random mid-transfer data changes
    for (int s = 0; s < 3; s++) begin
      for (int n = 0; n < ((s == 2) ? 1 : 6); n++) begin
        b  = 8'($urandom);
        cv = 8'($urandom);
        ca = $urandom_range(1, 16 * divs[s]);
        accept(s, b);
        check_xfer("rand", s, b, 16 * divs[s] + 2, ca, cv);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL provide parameter CLK_DIV, default 2: clk cycles per SCLK half-period; legal range 1..255.
REQ-002 SHALL have port clk  input  1  system clock, 27 MHz; all logic on rising edge; single clock domain.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port spi_enable  input  1  byte-start request from the LCD controller.
REQ-005 SHALL have port spi_data  input  8  byte to transmit; sampled only at acceptance.
REQ-006 SHALL have port spi_busy  output  1  high while a byte is being shifted.
REQ-007 SHALL have port spi_ready  output  1  single-cycle pulse marking byte completion.
REQ-008 SHALL have port sclk  output  1  SPI clock to the panel, mode 0 (CPOL=0, CPHA=0).
REQ-009 SHALL have port mosi  output  1  SPI data to the panel, MSB first.
REQ-010 SHALL leave chip select and data/command to the LCD controller; this block has no cs or dc ports.

Function
REQ-011 SHALL implement three states: IDLE, SHIFT, DONE.
REQ-012 IDLE: sclk=0, mosi=0, spi_busy=0, spi_ready=0; spi_enable=1 in cycle N latches spi_data into the shift register and enters SHIFT in cycle N+1.
REQ-013 SHIFT: spi_busy=1 in every cycle; mosi=bit7 of the latched byte from cycle N+1.
REQ-014 A half-period counter SHALL toggle sclk every CLK_DIV cycles: rising edges at N+1+(2k+1)*CLK_DIV, falling edges at N+1+(2k+2)*CLK_DIV, for k=0..7.
REQ-015 On each falling edge of sclk except the 8th, the shift register SHALL shift left and mosi SHALL present the next lower bit in the same cycle.
REQ-016 A 3-bit bit counter SHALL count falling edges; the 8th falling edge (cycle N+1+16*CLK_DIV) SHALL enter DONE in that cycle.
REQ-017 DONE: lasts exactly 1 cycle; spi_ready=1, spi_busy=0, sclk=0, mosi=0; then IDLE.
REQ-018 spi_busy and spi_ready SHALL never be high in the same cycle.
REQ-019 spi_enable SHALL be ignored in SHIFT and DONE; a held-high enable starts the next byte no earlier than the first IDLE cycle after DONE.
REQ-020 Changes on spi_data after acceptance SHALL NOT affect the byte in flight.
REQ-021 Total latency from acceptance cycle to spi_ready pulse SHALL be 1+16*CLK_DIV cycles (33 at default).
REQ-022 Back-to-back bytes: the minimum spacing between acceptances SHALL be 2+16*CLK_DIV cycles.
REQ-023 Counters SHALL be sized for CLK_DIV=255 without overflow; the half-period counter resets to 0 on every sclk toggle and on entry to SHIFT.
REQ-024 All outputs SHALL be registered (no combinational path from input to output).

Reset
REQ-025 rst=1 at a clock edge SHALL force IDLE, sclk=0, mosi=0, spi_busy=0, spi_ready=0, and clear all counters and the shift register.
REQ-026 Reset during SHIFT SHALL abort the byte with no spi_ready pulse; the first acceptance is possible in the first cycle with rst=0.
REQ-027 rst=1 concurrently with spi_enable=1 SHALL be treated as reset; the byte is not accepted.
REQ-028 Power-up initial values SHALL equal the reset values.

Verification
REQ-029 Single byte, CLK_DIV=2: spi_data=8'hA5 with a 1-cycle enable -> mosi bits 1,0,1,0,0,1,0,1 on 8 sclk rising edges; spi_ready at cycle +33; spi_busy high in cycles +1..+32.
REQ-030 LCD-style handshake: enable held until spi_busy is seen, sequence 8'h01 then 8'h11 -> two distinct transfers, exactly two spi_ready pulses, no byte duplicated or lost.
REQ-031 Data change mid-byte: spi_data moves from 8'h3A to 8'hFF at cycle +5 -> 8'h3A is shifted.
REQ-032 Reset at cycle +10 of an 8'h55 transfer -> outputs return to 0 in the next cycle, no spi_ready pulse; a following 8'h29 transfers correctly.
REQ-033 CLK_DIV=1 and CLK_DIV=255 with 8'h80 and 8'h01 -> sclk half-period equals CLK_DIV; spi_ready at cycle +17 and +4081 respectively.
REQ-034 Held enable with 8'hEF -> successive acceptances exactly 34 cycles apart at CLK_DIV=2.
